// File: rtl/addsub_batch_sequencer_if.sv
// Bus bundle for addsub_batch_sequencer: operand BRAM read port, adder
// operand/result path, result BRAM write port, and run control/status.
//   master : sequencer side (drives BRAM addresses, adder operands, status)
//   slave  : environment side (BRAM data, adder sum/cout, run control)
// Signals:
//   start_stop, add_sub   run request / 0=add 1=sub
//   douta                 operand word {A,B}
//   ena_a, addra          operand BRAM read enable / address
//   A, B, cin             adder operands and carry-in
//   sum, cout             adder result
//   wea, addrb, dinb      result BRAM write enable / address / {cout,sum}
//   busy, done, ovf_cnt   status
interface addsub_batch_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  start_stop;
  logic                  add_sub;
  logic [2*DATA_W-1:0]   douta;
  logic                  ena_a;
  logic [ADDR_W-1:0]     addra;
  logic [DATA_W-1:0]     A;
  logic [DATA_W-1:0]     B;
  logic                  cin;
  logic [DATA_W-1:0]     sum;
  logic                  cout;
  logic                  wea;
  logic [ADDR_W-1:0]     addrb;
  logic [DATA_W:0]       dinb;
  logic                  busy;
  logic                  done;
  logic [ADDR_W:0]       ovf_cnt;

  modport master (
    input  start_stop, add_sub, douta, sum, cout,
    output ena_a, addra, A, B, cin, wea, addrb, dinb, busy, done, ovf_cnt
  );

  modport slave (
    output start_stop, add_sub, douta, sum, cout,
    input  ena_a, addra, A, B, cin, wea, addrb, dinb, busy, done, ovf_cnt
  );
endinterface

// File: rtl/addsub_batch_sequencer.sv
// addsub_batch_sequencer
// Walks NUM_WORDS operand words out of the operand BRAM, feeds each through
// the external combinational adder (B inverted and cin=1 for subtract), and
// writes {cout,sum} to the result BRAM at the same address. One word takes
// 2+BRAM_LAT cycles: FETCH, WAIT x (BRAM_LAT-1), LOAD, WRITE.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    addsub_batch_sequencer_if.master (BRAM ports, adder, control/status)
// Configuration macro:
//   OVF_COUNT_EN  when defined, ovf_cnt counts carries (add) / borrows (sub)
//                 per batch; otherwise ovf_cnt is tied to 0.
module addsub_batch_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_WORDS = 16,
  parameter int BRAM_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  addsub_batch_sequencer_if.master  bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  // wait counter holds BRAM_LAT-2 down to 0
  localparam int WCW = (BRAM_LAT > 2) ? $clog2(BRAM_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_INIT = WCW'((BRAM_LAT > 1) ? BRAM_LAT - 2 : 0);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              mode;
  logic              ss_q;
  logic [WCW-1:0]    wait_cnt;
  logic              start_det;

  assign start_det = (state == S_IDLE) && bus.start_stop && !ss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      mode      <= 1'b0;
      // Treat start_stop as already high so a level held through reset
      // is not mistaken for a fresh rising edge.
      ss_q      <= 1'b1;
      wait_cnt  <= '0;
      bus.ena_a <= 1'b0;
      bus.addra <= '0;
      bus.A     <= '0;
      bus.B     <= '0;
      bus.cin   <= 1'b0;
      bus.wea   <= 1'b0;
      bus.addrb <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      ss_q <= bus.start_stop;
      if (state != S_IDLE && !bus.start_stop) begin
        // abort: operands and addresses hold, only strobes drop
        state     <= S_IDLE;
        bus.ena_a <= 1'b0;
        bus.wea   <= 1'b0;
        bus.busy  <= 1'b0;
        bus.done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_det) begin
            state     <= S_FETCH;
            ptr       <= '0;
            mode      <= bus.add_sub;
            bus.ena_a <= 1'b1;
            bus.addra <= '0;
            bus.busy  <= 1'b1;
          end
          S_FETCH: begin
            bus.ena_a <= 1'b0;
            if (BRAM_LAT > 1) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state <= S_LOAD;
            end
          end
          S_WAIT: begin
            if (wait_cnt == '0) state <= S_LOAD;
            else                wait_cnt <= wait_cnt - 1'b1;
          end
          S_LOAD: begin
            // subtract as A + ~B + 1
            bus.A     <= bus.douta[2*DATA_W-1:DATA_W];
            bus.B     <= mode ? ~bus.douta[DATA_W-1:0] : bus.douta[DATA_W-1:0];
            bus.cin   <= mode;
            bus.wea   <= 1'b1;
            bus.addrb <= ptr;
            state     <= S_WRITE;
          end
          S_WRITE: begin
            bus.wea <= 1'b0;
            ptr     <= ptr + 1'b1;
            if (ptr == LAST) begin
              state    <= S_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state     <= S_FETCH;
              bus.ena_a <= 1'b1;
              bus.addra <= ptr + 1'b1;
            end
          end
          S_DONE: begin
            bus.done <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // adder result goes straight to the result BRAM while wea is high
  assign bus.dinb = bus.wea ? {bus.cout, bus.sum} : '0;

`ifdef OVF_COUNT_EN
  logic [ADDR_W:0] ovf_q;
  logic            ovf_hit;

  // add: carry out; subtract: cout=0 means a borrow occurred
  assign ovf_hit = mode ? ~bus.cout : bus.cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           ovf_q <= '0;
    else if (start_det)                                   ovf_q <= '0;
    else if (state == S_WRITE && bus.start_stop && ovf_hit) ovf_q <= ovf_q + 1'b1;
  end

  assign bus.ovf_cnt = ovf_q;
`else
  assign bus.ovf_cnt = '0;
`endif
endmodule
